// File: rtl/sdram_interface.sv
// rtl/sdram_interface.sv - x16 SDR SDRAM pin driver: power-up init, auto-refresh, single-word access with auto-precharge (optional SDRAM_CMD_ERR_EN adds CMD_ERR)
module sdram_interface #(
  parameter int          INIT_WAIT    = 9600,
  parameter int          T_RP         = 1,
  parameter int          T_RCD        = 1,
  parameter int          T_RFC        = 4,
  parameter int          T_WR         = 2,
  parameter int          CAS_LAT      = 2,
  parameter int          REF_INTERVAL = 360,
  parameter logic [12:0] MODE_WORD    = 13'h020
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic [1:0]  CMD_IN,
  input  logic [1:0]  BA_IN,
  input  logic [12:0] ROW_IN,
  input  logic [8:0]  COL_IN,
  input  logic [15:0] DATA_IN,
  output logic        SDRAM_STATUS,
  output logic [15:0] READ_DATA,
  output logic        READ_VALID,
  output logic        SD_CKE,
  output logic        SD_CS_N,
  output logic        SD_RAS_N,
  output logic        SD_CAS_N,
  output logic        SD_WE_N,
  output logic [1:0]  SD_BA,
  output logic [12:0] SD_ADDR,
  output logic [1:0]  SD_DQM,
  output logic [15:0] SD_DQ_OUT,
  output logic        SD_DQ_OE,
  input  logic [15:0] SD_DQ_IN
`ifdef SDRAM_CMD_ERR_EN
  ,
  output logic        CMD_ERR
`endif
);

  // Command pin patterns {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_REF1,
    S_INIT_REF2,
    S_INIT_MRS,
    S_IDLE,
    S_ACT,
    S_WRITE,
    S_READ,
    S_REFRESH
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_ref_cnt;
  logic        r_ref_pending;
  logic        r_armed;
  logic [3:0]  r_cmd;
  logic        r_cke;
  logic        r_status;
  logic        r_read_valid;
  logic [15:0] r_read_data;
  logic [1:0]  r_sd_ba;
  logic [12:0] r_sd_addr;
  logic [1:0]  r_dqm;
  logic        r_dq_oe;
  logic [15:0] r_dq_out;
  logic [1:0]  r_ba;
  logic [8:0]  r_col;
  logic [15:0] r_data;
  logic        r_is_write;

  logic        w_accept;
  logic        w_done;
  logic        w_ref_tick;
  logic        w_ref_issue;

  // A read or write is taken only in IDLE, once per assertion of CMD_IN
  assign w_accept    = (r_state == S_IDLE) && r_armed &&
                       ((CMD_IN == 2'b01) || (CMD_IN == 2'b10));
  assign w_ref_tick  = (r_ref_cnt == 16'(REF_INTERVAL - 1));
  // An access ending with a refresh pending chains straight into REF so busy never drops
  assign w_ref_issue = r_ref_pending &&
                       (w_done || ((r_state == S_IDLE) && !w_accept));

  // End of the final NOP run of each sequence that returns to IDLE
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      S_INIT_MRS: w_done = (r_cnt == 16'd2);
      S_WRITE:    w_done = (r_cnt == 16'(T_WR + T_RP));
      S_READ:     w_done = (r_cnt == 16'(CAS_LAT + T_RP + 1));
      S_REFRESH:  w_done = (r_cnt == 16'(T_RFC));
      default:    w_done = 1'b0;
    endcase
  end

  // Free-running refresh interval counter; a tick while already pending is absorbed
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_ref_cnt     <= 16'd0;
      r_ref_pending <= 1'b0;
    end else begin
      r_ref_cnt     <= w_ref_tick ? 16'd0 : r_ref_cnt + 16'd1;
      r_ref_pending <= w_ref_tick | (r_ref_pending & ~w_ref_issue);
    end
  end

  // Re-arm on any idle CMD_IN cycle, disarm on acceptance; 11 leaves it unchanged
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_armed <= 1'b1;
    end else if (CMD_IN == 2'b00) begin
      r_armed <= 1'b1;
    end else if (w_accept) begin
      r_armed <= 1'b0;
    end
  end

  // Sequencer: every pin is registered here; the cycle counter restarts on each command
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_INIT_WAIT;
      r_cnt        <= 16'd0;
      r_cmd        <= C_NOP;
      r_cke        <= 1'b0;
      r_status     <= 1'b1;
      r_read_valid <= 1'b0;
      r_read_data  <= 16'd0;
      r_sd_ba      <= 2'b00;
      r_sd_addr    <= 13'd0;
      r_dqm        <= 2'b11;
      r_dq_oe      <= 1'b0;
      r_dq_out     <= 16'd0;
      r_ba         <= 2'b00;
      r_col        <= 9'd0;
      r_data       <= 16'd0;
      r_is_write   <= 1'b0;
    end else begin
      r_cke        <= 1'b1;
      r_cmd        <= C_NOP;
      r_dq_oe      <= 1'b0;
      r_dq_out     <= 16'd0;
      r_read_valid <= 1'b0;
      r_cnt        <= r_cnt + 16'd1;

      // Read word arrives CAS_LAT cycles after RD and is registered one edge later
      if ((r_state == S_READ) && (r_cnt == 16'(CAS_LAT + 1))) begin
        r_read_data  <= SD_DQ_IN;
        r_read_valid <= 1'b1;
      end

      if (w_done) begin
        r_cnt <= 16'd0;
        if (r_state == S_INIT_MRS) r_dqm <= 2'b00;
        if (r_ref_pending) begin
          r_cmd   <= C_REF;
          r_state <= S_REFRESH;
        end else begin
          r_state  <= S_IDLE;
          r_status <= 1'b0;
        end
      end else begin
        case (r_state)
          S_INIT_WAIT: begin
            if (r_cnt == 16'(INIT_WAIT - 1)) begin
              r_cmd     <= C_PRE;
              r_sd_addr <= 13'h0400;
              r_cnt     <= 16'd0;
              r_state   <= S_INIT_PRE;
            end
          end
          S_INIT_PRE: begin
            if (r_cnt == 16'(T_RP)) begin
              r_cmd   <= C_REF;
              r_cnt   <= 16'd0;
              r_state <= S_INIT_REF1;
            end
          end
          S_INIT_REF1: begin
            if (r_cnt == 16'(T_RFC)) begin
              r_cmd   <= C_REF;
              r_cnt   <= 16'd0;
              r_state <= S_INIT_REF2;
            end
          end
          S_INIT_REF2: begin
            if (r_cnt == 16'(T_RFC)) begin
              r_cmd     <= C_MRS;
              r_sd_addr <= MODE_WORD;
              r_sd_ba   <= 2'b00;
              r_cnt     <= 16'd0;
              r_state   <= S_INIT_MRS;
            end
          end
          S_IDLE: begin
            r_cnt <= 16'd0;
            if (w_accept) begin
              r_cmd      <= C_ACT;
              r_sd_ba    <= BA_IN;
              r_sd_addr  <= ROW_IN;
              r_ba       <= BA_IN;
              r_col      <= COL_IN;
              r_data     <= DATA_IN;
              r_is_write <= (CMD_IN == 2'b10);
              r_status   <= 1'b1;
              r_state    <= S_ACT;
            end else if (r_ref_pending) begin
              r_cmd    <= C_REF;
              r_status <= 1'b1;
              r_state  <= S_REFRESH;
            end
          end
          S_ACT: begin
            if (r_cnt == 16'(T_RCD)) begin
              r_cnt     <= 16'd0;
              r_sd_ba   <= r_ba;
              r_sd_addr <= {2'b00, 1'b1, 1'b0, r_col};
              if (r_is_write) begin
                r_cmd    <= C_WR;
                r_dq_oe  <= 1'b1;
                r_dq_out <= r_data;
                r_state  <= S_WRITE;
              end else begin
                r_cmd   <= C_RD;
                r_state <= S_READ;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef SDRAM_CMD_ERR_EN
  logic [1:0] r_cmd_prev;
  logic       r_cmd_err;

  // Sticky flag for protocol abuse: command changed while busy, or reserved code in IDLE
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_cmd_prev <= 2'b00;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_prev <= CMD_IN;
      if ((r_status && (CMD_IN != 2'b00) && (CMD_IN != r_cmd_prev)) ||
          ((r_state == S_IDLE) && (CMD_IN == 2'b11))) begin
        r_cmd_err <= 1'b1;
      end
    end
  end

  assign CMD_ERR = r_cmd_err;
`endif

  assign SDRAM_STATUS = r_status;
  assign READ_DATA    = r_read_data;
  assign READ_VALID   = r_read_valid;
  assign SD_CKE       = r_cke;
  assign SD_CS_N      = r_cmd[3];
  assign SD_RAS_N     = r_cmd[2];
  assign SD_CAS_N     = r_cmd[1];
  assign SD_WE_N      = r_cmd[0];
  assign SD_BA        = r_sd_ba;
  assign SD_ADDR      = r_sd_addr;
  assign SD_DQM       = r_dqm;
  assign SD_DQ_OUT    = r_dq_out;
  assign SD_DQ_OE     = r_dq_oe;

endmodule

// File: tb/tb_sdram_interface.sv
// tb/tb_sdram_interface.sv - directed-vector bench for sdram_interface
module tb_sdram_interface;

  localparam int INIT_WAIT    = 20;
  localparam int REF_INTERVAL = 200;
  localparam int CAS_LAT      = 2;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        CLK_48MHZ = 1'b0;
  logic        RESET     = 1'b1;
  logic [1:0]  CMD_IN    = 2'b00;
  logic [1:0]  BA_IN     = 2'b00;
  logic [12:0] ROW_IN    = 13'd0;
  logic [8:0]  COL_IN    = 9'd0;
  logic [15:0] DATA_IN   = 16'd0;
  logic [15:0] SD_DQ_IN  = 16'd0;
  logic        SDRAM_STATUS;
  logic [15:0] READ_DATA;
  logic        READ_VALID;
  logic        SD_CKE;
  logic        SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N;
  logic [1:0]  SD_BA;
  logic [12:0] SD_ADDR;
  logic [1:0]  SD_DQM;
  logic [15:0] SD_DQ_OUT;
  logic        SD_DQ_OE;
`ifdef SDRAM_CMD_ERR_EN
  logic        CMD_ERR;
`endif

  sdram_interface #(
    .INIT_WAIT   (INIT_WAIT),
    .REF_INTERVAL(REF_INTERVAL),
    .CAS_LAT     (CAS_LAT)
  ) dut (
    .CLK_48MHZ   (CLK_48MHZ),
    .RESET       (RESET),
    .CMD_IN      (CMD_IN),
    .BA_IN       (BA_IN),
    .ROW_IN      (ROW_IN),
    .COL_IN      (COL_IN),
    .DATA_IN     (DATA_IN),
    .SDRAM_STATUS(SDRAM_STATUS),
    .READ_DATA   (READ_DATA),
    .READ_VALID  (READ_VALID),
    .SD_CKE      (SD_CKE),
    .SD_CS_N     (SD_CS_N),
    .SD_RAS_N    (SD_RAS_N),
    .SD_CAS_N    (SD_CAS_N),
    .SD_WE_N     (SD_WE_N),
    .SD_BA       (SD_BA),
    .SD_ADDR     (SD_ADDR),
    .SD_DQM      (SD_DQM),
    .SD_DQ_OUT   (SD_DQ_OUT),
    .SD_DQ_OE    (SD_DQ_OE),
    .SD_DQ_IN    (SD_DQ_IN)
`ifdef SDRAM_CMD_ERR_EN
    ,
    .CMD_ERR     (CMD_ERR)
`endif
  );

  always #5 CLK_48MHZ = ~CLK_48MHZ;

  // Edge number since reset release: after edge k this reads k
  int ecnt;
  always @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  typedef struct {
    int          e;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        oe;
    logic [15:0] dq;
  } ev_t;

  ev_t         log_q[$];
  ev_t         mon_ev;
  logic [3:0]  pin_cmd;
  int          rd_e    = -100;
  logic [15:0] dq_ret  = 16'd0;
  int          vcount  = 0;
  int          valid_e = 0;
  logic [15:0] vdata   = 16'd0;

  assign pin_cmd = {SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N};

  // Pin monitor and SDRAM read model: word driven in the cycle before the capturing edge
  always @(negedge CLK_48MHZ) begin
    if (RESET) begin
      if (pin_cmd != C_NOP) begin
        mon_ev.e    = ecnt;
        mon_ev.cmd  = pin_cmd;
        mon_ev.ba   = SD_BA;
        mon_ev.addr = SD_ADDR;
        mon_ev.oe   = SD_DQ_OE;
        mon_ev.dq   = SD_DQ_OUT;
        log_q.push_back(mon_ev);
      end
      if (pin_cmd == C_RD) rd_e = ecnt;
      if (ecnt == rd_e + CAS_LAT + 1) SD_DQ_IN = dq_ret;
      else                            SD_DQ_IN = 16'h0000;
      if (READ_VALID) begin
        vcount  = vcount + 1;
        valid_e = ecnt;
        vdata   = READ_DATA;
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK_48MHZ);
    #1;
  endtask

  function automatic int count_cmd(input logic [3:0] c);
    int n;
    n = 0;
    foreach (log_q[i]) if (log_q[i].cmd == c) n++;
    return n;
  endfunction

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!SDRAM_STATUS) break;
      tick();
    end
    check("wait_idle_reached", SDRAM_STATUS, 1'b0);
  endtask

  task automatic wait_edge(input int target);
    for (int i = 0; i < 1000; i++) begin
      if (ecnt >= target) break;
      tick();
    end
    check("wait_edge_reached", ecnt, target);
  endtask

  typedef struct {
    int          e;
    logic [3:0]  cmd;
    logic [12:0] addr;
    bit          chk_addr;
  } ini_t;
  ini_t init_tbl[4];

  typedef struct {
    logic [1:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [8:0]  col;
    logic [15:0] data;
    logic [15:0] ret;
    int          busy;
    logic [12:0] rwaddr;
  } vec_t;
  vec_t vecs[4];

  task automatic run_init_check();
    int idle_e;
    idle_e = -1;
    tick();
    check("cke_after_release", SD_CKE, 1'b1);
    check("status_during_init", SDRAM_STATUS, 1'b1);
    check("dqm_during_init", SD_DQM, 2'b11);
    for (int i = 0; i < 200; i++) begin
      if (!SDRAM_STATUS) begin
        idle_e = ecnt;
        break;
      end
      tick();
    end
    check("init_idle_edge", idle_e, 35);
    check("init_cmd_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        check($sformatf("init%0d_edge", i), log_q[i].e, init_tbl[i].e);
        check($sformatf("init%0d_cmd", i), log_q[i].cmd, init_tbl[i].cmd);
        if (init_tbl[i].chk_addr) begin
          check($sformatf("init%0d_addr", i), log_q[i].addr, init_tbl[i].addr);
          check($sformatf("init%0d_ba", i), log_q[i].ba, 2'b00);
        end
      end
    end
    check("dqm_after_init", SD_DQM, 2'b00);
  endtask

  task automatic do_access(input vec_t v, input int idx);
    int acc, busy, v0;
    bit seen;
    wait_idle(50);
    log_q.delete();
    v0      = vcount;
    dq_ret  = v.ret;
    CMD_IN  = v.cmd;
    BA_IN   = v.ba;
    ROW_IN  = v.row;
    COL_IN  = v.col;
    DATA_IN = v.data;
    acc  = ecnt + 1;
    busy = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (SDRAM_STATUS) begin
        busy++;
        seen   = 1;
        CMD_IN = 2'b00;
      end else if (seen) begin
        break;
      end
    end
    CMD_IN = 2'b00;
    check($sformatf("v%0d_busy_cycles", idx), busy, v.busy);
    check($sformatf("v%0d_cmd_count", idx), log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check($sformatf("v%0d_act_edge", idx), log_q[0].e, acc);
      check($sformatf("v%0d_act_cmd", idx), log_q[0].cmd, C_ACT);
      check($sformatf("v%0d_act_ba", idx), log_q[0].ba, v.ba);
      check($sformatf("v%0d_act_addr", idx), log_q[0].addr, v.row);
      check($sformatf("v%0d_rw_edge", idx), log_q[1].e, acc + 2);
      check($sformatf("v%0d_rw_cmd", idx), log_q[1].cmd, (v.cmd == 2'b10) ? C_WR : C_RD);
      check($sformatf("v%0d_rw_ba", idx), log_q[1].ba, v.ba);
      check($sformatf("v%0d_rw_addr", idx), log_q[1].addr, v.rwaddr);
      check($sformatf("v%0d_rw_oe", idx), log_q[1].oe, (v.cmd == 2'b10));
      if (v.cmd == 2'b10) check($sformatf("v%0d_wr_dq", idx), log_q[1].dq, v.data);
    end
    if (v.cmd == 2'b01) begin
      check($sformatf("v%0d_valid_count", idx), vcount - v0, 1);
      check($sformatf("v%0d_valid_edge", idx), valid_e, acc + 6);
      check($sformatf("v%0d_read_data", idx), vdata, v.ret);
      check($sformatf("v%0d_read_data_held", idx), READ_DATA, v.ret);
    end else begin
      check($sformatf("v%0d_valid_count", idx), vcount - v0, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy, acc;
    bit seen;

    init_tbl[0] = '{20, C_PRE, 13'h0400, 1'b1};
    init_tbl[1] = '{22, C_REF, 13'h0000, 1'b0};
    init_tbl[2] = '{27, C_REF, 13'h0000, 1'b0};
    init_tbl[3] = '{32, C_MRS, 13'h0020, 1'b1};

    vecs[0] = '{2'b10, 2'd2, 13'h1ABC, 9'h055, 16'hBEEF, 16'h0000, 6, 13'h0455};
    vecs[1] = '{2'b01, 2'd2, 13'h1ABC, 9'h055, 16'h0000, 16'hBEEF, 7, 13'h0455};
    vecs[2] = '{2'b10, 2'd1, 13'h0000, 9'h1FF, 16'h1234, 16'h0000, 6, 13'h05FF};
    vecs[3] = '{2'b01, 2'd3, 13'h1FFF, 9'h000, 16'h0000, 16'hA5C3, 7, 13'h0400};

    // Reset state
    #1 RESET = 1'b0;
    repeat (3) tick();
    check("rst_status", SDRAM_STATUS, 1'b1);
    check("rst_read_valid", READ_VALID, 1'b0);
    check("rst_read_data", READ_DATA, 16'h0000);
    check("rst_cke", SD_CKE, 1'b0);
    check("rst_cmd", pin_cmd, C_NOP);
    check("rst_addr", SD_ADDR, 13'd0);
    check("rst_ba", SD_BA, 2'b00);
    check("rst_dqm", SD_DQM, 2'b11);
    check("rst_oe", SD_DQ_OE, 1'b0);

    // Power-up init
    log_q.delete();
    RESET = 1'b1;
    run_init_check();

    // Table-driven accesses
    for (int i = 0; i < 4; i++) do_access(vecs[i], i);

    // Reserved command 11 in IDLE is ignored
    wait_idle(50);
    log_q.delete();
    CMD_IN = 2'b11;
    busy = 0;
    repeat (6) begin
      tick();
      if (SDRAM_STATUS) busy++;
    end
    CMD_IN = 2'b00;
    check("cmd11_busy", busy, 0);
    check("cmd11_no_pins", log_q.size(), 0);

    // Held write: one command per assertion, re-armed by a single 00 cycle
    wait_idle(50);
    log_q.delete();
    CMD_IN  = 2'b10;
    BA_IN   = 2'd0;
    ROW_IN  = 13'h0005;
    COL_IN  = 9'h005;
    DATA_IN = 16'h1111;
    repeat (20) tick();
    check("hold_single_write", count_cmd(C_WR), 1);
    check("hold_status_idle", SDRAM_STATUS, 1'b0);
    CMD_IN = 2'b00;
    tick();
    CMD_IN = 2'b10;
    repeat (15) tick();
    check("rearm_second_write", count_cmd(C_WR), 2);
    CMD_IN = 2'b00;
    tick();

    // Periodic refresh: pending at edge REF_INTERVAL, REF on the next edge
    wait_idle(50);
    log_q.delete();
    wait_edge(215);
    check("refresh_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("refresh_edge", log_q[0].e, REF_INTERVAL + 1);
      check("refresh_cmd", log_q[0].cmd, C_REF);
    end

    // Command accepted on the edge that raises refresh_pending
    wait_edge(2 * REF_INTERVAL - 1);
    log_q.delete();
    CMD_IN  = 2'b10;
    BA_IN   = 2'd0;
    ROW_IN  = 13'h0ACE;
    COL_IN  = 9'h033;
    DATA_IN = 16'h5A5A;
    acc  = ecnt + 1;
    busy = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (SDRAM_STATUS) begin
        busy++;
        seen   = 1;
        CMD_IN = 2'b00;
      end else if (seen) begin
        break;
      end
    end
    CMD_IN = 2'b00;
    check("collide_busy_cycles", busy, 11);
    check("collide_cmd_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      check("collide_act_edge", log_q[0].e, acc);
      check("collide_act_cmd", log_q[0].cmd, C_ACT);
      check("collide_wr_cmd", log_q[1].cmd, C_WR);
      check("collide_ref_edge", log_q[2].e, acc + 6);
      check("collide_ref_cmd", log_q[2].cmd, C_REF);
    end

    // Reset in the middle of a write
    wait_idle(50);
    CMD_IN  = 2'b10;
    BA_IN   = 2'd1;
    ROW_IN  = 13'h0222;
    COL_IN  = 9'h011;
    DATA_IN = 16'hCAFE;
    tick();
    tick();
    check("midwr_busy_before_reset", SDRAM_STATUS, 1'b1);
    RESET = 1'b0;
    #1;
    check("midwr_rst_cmd", pin_cmd, C_NOP);
    check("midwr_rst_cke", SD_CKE, 1'b0);
    check("midwr_rst_status", SDRAM_STATUS, 1'b1);
    check("midwr_rst_oe", SD_DQ_OE, 1'b0);
    check("midwr_rst_dqm", SD_DQM, 2'b11);
    CMD_IN = 2'b00;
    repeat (3) tick();
    log_q.delete();
    RESET = 1'b1;
    run_init_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
